tag_free_list: RTL

//   Allocator/releaser for a pool of N hardware tags (MSHR, store-buffer or ROB slot IDs).

---
 rtl/tag_free_list_pkg.sv | 9 +
 rtl/tag_pick_lowest.sv | 27 ++
 rtl/tag_free_list.sv | 99 +++++++++
 3 files changed

// File: rtl/tag_free_list_pkg.sv
// Shared pool sizing for the tag free list and its helpers.
// Instantiating blocks override N per pool; these are the default pool dimensions.
package tag_free_list_pkg;

    localparam int TAG_N     = 16;
    localparam int TAG_IDX_W = $clog2(TAG_N);
    localparam int TAG_CNT_W = TAG_IDX_W + 1;

endpackage

// File: rtl/tag_pick_lowest.sv
// Lowest-set-bit picker: isolates the lowest 1 in req and encodes its position.
// 'any' is low when req is all zeros, in which case idx is 0.
module tag_pick_lowest
    import tag_free_list_pkg::*;
#(
    parameter int N     = TAG_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        // Two's-complement trick keeps only the lowest set bit.
        onehot = req & (~req + {{(N-1){1'b0}}, 1'b1});
        any    = |req;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tag_free_list.sv
// Tag pool allocator: grants the lowest free tag combinationally, takes returned tags
// back, and keeps a registered free count that always matches the busy map.
module tag_free_list
    import tag_free_list_pkg::*;
#(
    parameter int N     = TAG_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             free_valid,
    input  logic [IDX_W-1:0] free_idx,
    output logic [IDX_W:0]   free_cnt,
    output logic             empty,
    output logic             err_free
);

    localparam int               CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic [N-1:0]     busy_q, busy_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic             empty_q, empty_d;
    logic             err_free_q, err_free_d;

    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [N-1:0]     free_onehot;
    logic             free_legal;

    tag_pick_lowest #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req    (~busy_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Handshake: alloc_req is a one-cycle request; alloc_gnt answers in the same cycle
    // and the tag in alloc_idx is owned by the requester from the next edge onward.
    assign alloc_gnt = alloc_req & ~flush & ~empty_q & pick_any;
    assign alloc_idx = pick_idx;

    // Out-of-range indices match no bit, so they fall through as illegal frees.
    always_comb begin
        free_onehot = '0;
        for (int i = 0; i < N; i++) begin
            free_onehot[i] = (free_idx == IDX_W'(i));
        end
        free_legal = free_valid & (|(free_onehot & busy_q));
    end

    always_comb begin
        busy_d     = busy_q;
        free_cnt_d = free_cnt_q;
        err_free_d = 1'b0;
        if (flush) begin
            busy_d     = '0;
            free_cnt_d = N_CNT;
        end else begin
            if (alloc_gnt) begin
                busy_d = busy_d | pick_onehot;
            end
            if (free_legal) begin
                busy_d = busy_d & ~free_onehot;
            end
            free_cnt_d = free_cnt_q - CNT_W'(alloc_gnt) + CNT_W'(free_legal);
            err_free_d = free_valid & ~free_legal;
        end
        empty_d = (free_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            free_cnt_q <= N_CNT;
            empty_q    <= 1'b0;
            err_free_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            empty_q    <= empty_d;
            err_free_q <= err_free_d;
        end
    end

    assign free_cnt = free_cnt_q;
    assign empty    = empty_q;
    assign err_free = err_free_q;

    assert property (@(posedge clk) disable iff (reset)
                     free_cnt_q == N_CNT - CNT_W'($countones(busy_q)))
        else $error("free count out of step with busy map");

endmodule
